branch_hazard_controller: RTL and testbench
===========================================

Name: branch_hazard_controller

Overview:
- Stall/flush sequencer for the ID stage of the 5-stage pipeline.
- Branch/jump operands are compared in ID. EX/MEM-to-ID forwarding resolves only ALU results already in MEM.
- Detects operand dependencies that forwarding cannot cover and holds PC and IF/ID for the required 1 or 2 cycles, inserting ID/EX bubbles.
- Flushes IF/ID on taken branches and jumps; keeps performance counters of stall and flush cycles.

Parameters:
- DELAY_SLOT, 0, 1 = fetched instruction after branch/jump executes (no flush); 0 = squash it.
- CNT_W, 32, width of stall_count and flush_count.

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  asynchronous, active-high reset.
- ext_stall  in  1  global freeze (memory wait); pipeline holds everything.
- ID_Branch  in  1  conditional branch in ID (reads rs, rt).
- ID_JumpReg  in  1  jr/jalr in ID (reads rs).
- ID_Jump  in  1  j/jal in ID (no register read).
- ID_BranchTaken  in  1  branch comparison result, valid only when operands are ready.
- ID_UseRs  in  1  non-branch instruction reads rs.
- ID_UseRt  in  1  non-branch instruction reads rt.
- ID_RegRs  in  5  rs address.
- ID_RegRt  in  5  rt address.
- EX_RegWrite  in  1  EX-stage instruction writes the register file.
- EX_MemRead  in  1  EX-stage instruction is a load.
- EX_RegWrAddr  in  5  EX destination.
- MEM_RegWrite  in  1  MEM-stage instruction writes the register file.
- MEM_MemRead  in  1  MEM-stage instruction is a load.
- MEM_RegWrAddr  in  5  MEM destination.
- PC_Write  out  1  1 = PC updates.
- IF_ID_Write  out  1  1 = IF/ID register loads.
- IF_ID_Flush  out  1  1 = IF/ID loads a nop.
- ID_EX_Bubble  out  1  1 = ID/EX loads a nop.
- stall_state  out  2  FSM state, for debug.
- stall_count  out  CNT_W  cycles with a hazard stall.
- flush_count  out  CNT_W  cycles with IF_ID_Flush asserted.

Behaviour:
- Register-write match definitions:
  - exm(r) = EX_RegWrite & EX_RegWrAddr != 0 & EX_RegWrAddr == r.
  - memm(r) = MEM_RegWrite & MEM_RegWrAddr != 0 & MEM_RegWrAddr == r.
- Branch source set: rs if ID_Branch or ID_JumpReg; rt if ID_Branch.
- Stall need, evaluated only in RUN; the first matching rule wins:
  - branch source exm & EX_MemRead: need = 2.
  - branch source exm & !EX_MemRead: need = 1.
  - branch source memm & MEM_MemRead: need = 1.
  - non-branch use (ID_UseRs→rs, ID_UseRt→rt) exm & EX_MemRead: need = 1.
  - otherwise: need = 0.
- The register file writes in the first half-cycle, so no WB hazard exists.
- FSM states: RUN=0, STALL1=1 (one more stall cycle pending), HOLD=2 (frozen by ext_stall, for debug only; the frozen state is otherwise retained).
- RUN transitions:
  - need = 0: no stall.
  - need = 1: stall this cycle, stay RUN, and re-evaluate next cycle (the bubble has advanced).
  - need = 2: stall this cycle, go to STALL1.
- STALL1: stall unconditionally, without re-evaluating; then go to RUN.
- Stall cycle outputs: PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1, IF_ID_Flush=0. stall_count increments.
- Non-stall cycle in RUN:
  - PC_Write=1, IF_ID_Write=1, ID_EX_Bubble=0.
  - take = ID_Jump | ID_JumpReg | (ID_Branch & ID_BranchTaken).
  - IF_ID_Flush = take & !DELAY_SLOT. flush_count increments when it is 1.
- ID_BranchTaken is ignored during any stall cycle, so no flush occurs while operands are pending.
- ext_stall=1 has the highest priority after reset:
  - PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=0, IF_ID_Flush=0.
  - FSM state and both counters are frozen.
  - stall_state reads 2 while frozen; the underlying RUN/STALL1 state is resumed when ext_stall drops.
- Reset, asynchronous:
  - state=RUN, stall_count=0, flush_count=0.
  - While reset=1: PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1, IF_ID_Flush=1.
  - Reset mid-STALL1 aborts the stall; the first cycle after release is evaluated in RUN.
- Counters wrap modulo 2^CNT_W.
- Control outputs are combinational from state and inputs (zero latency). State and counters update on posedge clk.

Decomposition:
- Shared package/header: state encodings RUN/STALL1/HOLD and NOP-control constants.
- One sub-module is natural: hazard_need_decoder, combinational, producing the 2-bit need from the match rules. The FSM, output muxing and counters stay in the top.

Test Plan:
- lw $1 in EX (EX_MemRead=1, EX_RegWrAddr=1), beq $1,$2 in ID:
  - cycles 1–2: PC_Write=0, ID_EX_Bubble=1, stall_state=0 then 1.
  - cycle 3: PC_Write=1; stall_count=2.
- add $3 in EX, beq $3,$0 in ID, ID_BranchTaken=1, DELAY_SLOT=0:
  - cycle 1: stall.
  - cycle 2 (add now in MEM, no hazard): IF_ID_Flush=1, flush_count=1.
- lw $4 in EX, add $5,$4,$4 (ID_UseRs=1) in ID:
  - exactly one stall cycle.
  - Same case with EX_RegWrAddr=0: no stall.
- ext_stall=1 asserted during STALL1 for 3 cycles:
  - outputs frozen (PC_Write=0, ID_EX_Bubble=0), stall_state=2, stall_count unchanged.
  - After release: one stall cycle, then RUN.
- Taken jr $31 with no hazard:
  - DELAY_SLOT=0: IF_ID_Flush=1.
  - DELAY_SLOT=1: IF_ID_Flush=0, flush_count stays 0.
- Reset asserted during STALL1:
  - immediate PC_Write=0, ID_EX_Bubble=1, IF_ID_Flush=1, counters=0.
  - After release: stall_state=0.

Source files
------------

// File: rtl/branch_hazard_controller_pkg.sv
`default_nettype none
// ============================================================================
// branch_hazard_controller_pkg : state encodings and control-word constants
// Revision 1.0
// ============================================================================
package branch_hazard_controller_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_STALL1 = 2'd1,
    ST_HOLD   = 2'd2
  } state_e;

  localparam logic [1:0] NEED_NONE = 2'd0;
  localparam logic [1:0] NEED_ONE  = 2'd1;
  localparam logic [1:0] NEED_TWO  = 2'd2;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_bubble;
  } ctrl_t;

  localparam ctrl_t CTRL_RESET  = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b1, id_ex_bubble: 1'b1};
  localparam ctrl_t CTRL_FREEZE = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0, id_ex_bubble: 1'b0};
  localparam ctrl_t CTRL_STALL  = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0, id_ex_bubble: 1'b1};
  localparam ctrl_t CTRL_RUN    = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0, id_ex_bubble: 1'b0};

endpackage
`default_nettype wire

// File: rtl/branch_hazard_controller_need.sv
`default_nettype none
// ============================================================================
// hazard_need_decoder : number of stall cycles an ID-stage instruction needs
// Revision 1.0
// ============================================================================
module hazard_need_decoder
  import branch_hazard_controller_pkg::*;
(
  input  logic       ID_Branch,
  input  logic       ID_JumpReg,
  input  logic       ID_UseRs,
  input  logic       ID_UseRt,
  input  logic [4:0] ID_RegRs,
  input  logic [4:0] ID_RegRt,
  input  logic       EX_RegWrite,
  input  logic       EX_MemRead,
  input  logic [4:0] EX_RegWrAddr,
  input  logic       MEM_RegWrite,
  input  logic       MEM_MemRead,
  input  logic [4:0] MEM_RegWrAddr,
  output logic [1:0] need
);

  logic ex_rs, ex_rt, mem_rs, mem_rt;
  logic br_rs, br_rt;
  logic br_ex, br_mem, use_ex;

  always_comb begin
    ex_rs  = EX_RegWrite  && (EX_RegWrAddr  != 5'd0) && (EX_RegWrAddr  == ID_RegRs);
    ex_rt  = EX_RegWrite  && (EX_RegWrAddr  != 5'd0) && (EX_RegWrAddr  == ID_RegRt);
    mem_rs = MEM_RegWrite && (MEM_RegWrAddr != 5'd0) && (MEM_RegWrAddr == ID_RegRs);
    mem_rt = MEM_RegWrite && (MEM_RegWrAddr != 5'd0) && (MEM_RegWrAddr == ID_RegRt);

    br_rs = ID_Branch | ID_JumpReg;
    br_rt = ID_Branch;

    br_ex  = (br_rs & ex_rs)  | (br_rt & ex_rt);
    br_mem = (br_rs & mem_rs) | (br_rt & mem_rt);
    use_ex = (ID_UseRs & ex_rs) | (ID_UseRt & ex_rt);

    // Priority order matters: a load in EX feeding a branch needs two cycles.
    need = NEED_NONE;
    if (br_ex && EX_MemRead)
      need = NEED_TWO;
    else if (br_ex)
      need = NEED_ONE;
    else if (br_mem && MEM_MemRead)
      need = NEED_ONE;
    else if (use_ex && EX_MemRead)
      need = NEED_ONE;
  end

endmodule
`default_nettype wire

// File: rtl/branch_hazard_controller.sv
`default_nettype none
// ============================================================================
// branch_hazard_controller : ID-stage stall/flush sequencer with perf counters
// Revision 1.0
// ============================================================================
module branch_hazard_controller
  import branch_hazard_controller_pkg::*;
#(
  parameter int DELAY_SLOT = 0,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ext_stall,
  input  logic             ID_Branch,
  input  logic             ID_JumpReg,
  input  logic             ID_Jump,
  input  logic             ID_BranchTaken,
  input  logic             ID_UseRs,
  input  logic             ID_UseRt,
  input  logic [4:0]       ID_RegRs,
  input  logic [4:0]       ID_RegRt,
  input  logic             EX_RegWrite,
  input  logic             EX_MemRead,
  input  logic [4:0]       EX_RegWrAddr,
  input  logic             MEM_RegWrite,
  input  logic             MEM_MemRead,
  input  logic [4:0]       MEM_RegWrAddr,
  output logic             PC_Write,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Bubble,
  output logic [1:0]       stall_state,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic SQUASH = (DELAY_SLOT == 0);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;
  logic [1:0]       need;
  logic             stall_cyc;
  logic             flush_cyc;
  ctrl_t            ctrl;

  hazard_need_decoder u_need (
    .ID_Branch     (ID_Branch),
    .ID_JumpReg    (ID_JumpReg),
    .ID_UseRs      (ID_UseRs),
    .ID_UseRt      (ID_UseRt),
    .ID_RegRs      (ID_RegRs),
    .ID_RegRt      (ID_RegRt),
    .EX_RegWrite   (EX_RegWrite),
    .EX_MemRead    (EX_MemRead),
    .EX_RegWrAddr  (EX_RegWrAddr),
    .MEM_RegWrite  (MEM_RegWrite),
    .MEM_MemRead   (MEM_MemRead),
    .MEM_RegWrAddr (MEM_RegWrAddr),
    .need          (need)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_RUN;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      state_q       <= state_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    stall_cyc = 1'b0;
    flush_cyc = 1'b0;
    if (!reset && !ext_stall) begin
      case (state_q)
        ST_STALL1: begin
          stall_cyc = 1'b1;
          state_d   = ST_RUN;
        end
        default: begin
          stall_cyc = (need != NEED_NONE);
          state_d   = (need == NEED_TWO) ? ST_STALL1 : ST_RUN;
          // Branch outcome is only trusted once its operands are ready.
          flush_cyc = !stall_cyc && SQUASH &&
                      (ID_Jump | ID_JumpReg | (ID_Branch & ID_BranchTaken));
        end
      endcase
    end
    stall_count_d = stall_count_q + CNT_W'(stall_cyc);
    flush_count_d = flush_count_q + CNT_W'(flush_cyc);
  end

  always_comb begin
    ctrl             = CTRL_RUN;
    ctrl.if_id_flush = flush_cyc;
    if (reset)
      ctrl = CTRL_RESET;
    else if (ext_stall)
      ctrl = CTRL_FREEZE;
    else if (stall_cyc)
      ctrl = CTRL_STALL;

    PC_Write     = ctrl.pc_write;
    IF_ID_Write  = ctrl.if_id_write;
    IF_ID_Flush  = ctrl.if_id_flush;
    ID_EX_Bubble = ctrl.id_ex_bubble;
    stall_state  = (!reset && ext_stall) ? ST_HOLD : state_q;
    stall_count  = stall_count_q;
    flush_count  = flush_count_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_branch_hazard_controller.sv
`default_nettype none
// ============================================================================
// tb_branch_hazard_controller : directed vectors, queue-based scoreboard
// Revision 1.0
// ============================================================================
module tb_branch_hazard_controller;

  logic clk = 1'b0;
  logic reset, ext_stall;
  logic ID_Branch, ID_JumpReg, ID_Jump, ID_BranchTaken, ID_UseRs, ID_UseRt;
  logic [4:0] ID_RegRs, ID_RegRt, EX_RegWrAddr, MEM_RegWrAddr;
  logic EX_RegWrite, EX_MemRead, MEM_RegWrite, MEM_MemRead;

  logic pcw0, ifw0, fl0, bub0, pcw1, ifw1, fl1, bub1;
  logic [1:0] st0, st1;
  logic [31:0] sc0, fc0, sc1, fc1;

  always #5 clk = ~clk;

  branch_hazard_controller #(.DELAY_SLOT(0), .CNT_W(32)) dut0 (
    .clk(clk), .reset(reset), .ext_stall(ext_stall),
    .ID_Branch(ID_Branch), .ID_JumpReg(ID_JumpReg), .ID_Jump(ID_Jump),
    .ID_BranchTaken(ID_BranchTaken), .ID_UseRs(ID_UseRs), .ID_UseRt(ID_UseRt),
    .ID_RegRs(ID_RegRs), .ID_RegRt(ID_RegRt),
    .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead), .EX_RegWrAddr(EX_RegWrAddr),
    .MEM_RegWrite(MEM_RegWrite), .MEM_MemRead(MEM_MemRead), .MEM_RegWrAddr(MEM_RegWrAddr),
    .PC_Write(pcw0), .IF_ID_Write(ifw0), .IF_ID_Flush(fl0), .ID_EX_Bubble(bub0),
    .stall_state(st0), .stall_count(sc0), .flush_count(fc0)
  );

  branch_hazard_controller #(.DELAY_SLOT(1), .CNT_W(32)) dut1 (
    .clk(clk), .reset(reset), .ext_stall(ext_stall),
    .ID_Branch(ID_Branch), .ID_JumpReg(ID_JumpReg), .ID_Jump(ID_Jump),
    .ID_BranchTaken(ID_BranchTaken), .ID_UseRs(ID_UseRs), .ID_UseRt(ID_UseRt),
    .ID_RegRs(ID_RegRs), .ID_RegRt(ID_RegRt),
    .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead), .EX_RegWrAddr(EX_RegWrAddr),
    .MEM_RegWrite(MEM_RegWrite), .MEM_MemRead(MEM_MemRead), .MEM_RegWrAddr(MEM_RegWrAddr),
    .PC_Write(pcw1), .IF_ID_Write(ifw1), .IF_ID_Flush(fl1), .ID_EX_Bubble(bub1),
    .stall_state(st1), .stall_count(sc1), .flush_count(fc1)
  );

  typedef struct {
    int id;
    int pcw, ifw, fl, bub, st, sc, fc, fl1, fc1;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input int id, input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL vec%0d %s: got=%0d want=%0d", id, name, act, req);
    end
  endtask

  // Monitor: one expectation per cycle, sampled mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check(e.id, "PC_Write",       int'(pcw0), e.pcw);
        check(e.id, "IF_ID_Write",    int'(ifw0), e.ifw);
        check(e.id, "IF_ID_Flush",    int'(fl0),  e.fl);
        check(e.id, "ID_EX_Bubble",   int'(bub0), e.bub);
        check(e.id, "stall_state",    int'(st0),  e.st);
        check(e.id, "stall_count",    int'(sc0),  e.sc);
        check(e.id, "flush_count",    int'(fc0),  e.fc);
        check(e.id, "ds1_IF_ID_Flush", int'(fl1), e.fl1);
        check(e.id, "ds1_flush_count", int'(fc1), e.fc1);
        check(e.id, "ds1_PC_Write",   int'(pcw1), e.pcw);
        check(e.id, "ds1_stall_state", int'(st1), e.st);
      end
    end
  end

  task automatic cyc(input int id, input int pcw, ifw, fl, bub, st, sc, fc, fl1, fc1);
    exp_t e;
    e = '{id: id, pcw: pcw, ifw: ifw, fl: fl, bub: bub, st: st, sc: sc, fc: fc, fl1: fl1, fc1: fc1};
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ext_stall = 0;
    ID_Branch = 0; ID_JumpReg = 0; ID_Jump = 0; ID_BranchTaken = 0;
    ID_UseRs = 0; ID_UseRt = 0; ID_RegRs = 0; ID_RegRt = 0;
    EX_RegWrite = 0; EX_MemRead = 0; EX_RegWrAddr = 0;
    MEM_RegWrite = 0; MEM_MemRead = 0; MEM_RegWrAddr = 0;
  endtask

  task automatic lw1_beq1();
    clear_inputs();
    ID_Branch = 1; ID_BranchTaken = 1; ID_RegRs = 5'd1; ID_RegRt = 5'd2;
    EX_RegWrite = 1; EX_MemRead = 1; EX_RegWrAddr = 5'd1;
  endtask

  initial begin
    int waited;
    clear_inputs();
    reset = 1;
    @(posedge clk);
    #1;
    //   id  pcw ifw fl bub st sc fc fl1 fc1
    cyc(0,   0,  0,  1, 1,  0, 0, 0, 1,  0);   // held in reset
    reset = 0;
    cyc(1,   1,  1,  0, 0,  0, 0, 0, 0,  0);   // idle

    // lw $1 in EX, beq $1,$2 in ID: two stall cycles
    lw1_beq1();
    cyc(10,  0,  0,  0, 1,  0, 0, 0, 0,  0);
    EX_RegWrite = 0; EX_MemRead = 0; EX_RegWrAddr = 0;
    MEM_RegWrite = 1; MEM_MemRead = 1; MEM_RegWrAddr = 5'd1;
    cyc(11,  0,  0,  0, 1,  1, 1, 0, 0,  0);
    MEM_RegWrite = 0; MEM_MemRead = 0; MEM_RegWrAddr = 0;
    cyc(12,  1,  1,  1, 0,  0, 2, 0, 0,  0);

    // add $3 in EX, beq $3,$0 taken: one stall, then flush
    clear_inputs();
    ID_Branch = 1; ID_BranchTaken = 1; ID_RegRs = 5'd3; ID_RegRt = 5'd0;
    EX_RegWrite = 1; EX_RegWrAddr = 5'd3;
    cyc(20,  0,  0,  0, 1,  0, 2, 1, 0,  0);
    EX_RegWrite = 0; EX_RegWrAddr = 0;
    MEM_RegWrite = 1; MEM_RegWrAddr = 5'd3;
    cyc(21,  1,  1,  1, 0,  0, 3, 1, 0,  0);

    // lw $4 in EX, add $5,$4,$4: single load-use stall
    clear_inputs();
    ID_UseRs = 1; ID_RegRs = 5'd4; ID_RegRt = 5'd4;
    EX_RegWrite = 1; EX_MemRead = 1; EX_RegWrAddr = 5'd4;
    cyc(30,  0,  0,  0, 1,  0, 3, 2, 0,  0);
    EX_RegWrite = 0; EX_MemRead = 0; EX_RegWrAddr = 0;
    MEM_RegWrite = 1; MEM_MemRead = 1; MEM_RegWrAddr = 5'd4;
    cyc(31,  1,  1,  0, 0,  0, 4, 2, 0,  0);
    MEM_RegWrite = 0; MEM_MemRead = 0; MEM_RegWrAddr = 0;
    EX_RegWrite = 1; EX_MemRead = 1; EX_RegWrAddr = 5'd0;   // $0 never hazards
    cyc(32,  1,  1,  0, 0,  0, 4, 2, 0,  0);

    // ext_stall held for three cycles while in STALL1
    lw1_beq1();
    cyc(40,  0,  0,  0, 1,  0, 4, 2, 0,  0);
    ext_stall = 1;
    cyc(41,  0,  0,  0, 0,  2, 5, 2, 0,  0);
    cyc(42,  0,  0,  0, 0,  2, 5, 2, 0,  0);
    cyc(43,  0,  0,  0, 0,  2, 5, 2, 0,  0);
    ext_stall = 0;
    EX_RegWrite = 0; EX_MemRead = 0; EX_RegWrAddr = 0; ID_BranchTaken = 0;
    cyc(44,  0,  0,  0, 1,  1, 5, 2, 0,  0);
    cyc(45,  1,  1,  0, 0,  0, 6, 2, 0,  0);

    // jr $31 / j without hazards
    clear_inputs();
    ID_JumpReg = 1; ID_RegRs = 5'd31;
    cyc(50,  1,  1,  1, 0,  0, 6, 2, 0,  0);
    clear_inputs();
    ID_Jump = 1;
    cyc(51,  1,  1,  1, 0,  0, 6, 3, 0,  0);
    // jr $31 with ALU producer in EX: stall, no flush
    clear_inputs();
    ID_JumpReg = 1; ID_RegRs = 5'd31;
    EX_RegWrite = 1; EX_RegWrAddr = 5'd31;
    cyc(52,  0,  0,  0, 1,  0, 6, 4, 0,  0);
    // branch rt source fed by a load in MEM
    clear_inputs();
    ID_Branch = 1; ID_BranchTaken = 1; ID_RegRs = 5'd2; ID_RegRt = 5'd7;
    MEM_RegWrite = 1; MEM_MemRead = 1; MEM_RegWrAddr = 5'd7;
    cyc(53,  0,  0,  0, 1,  0, 7, 4, 0,  0);
    // address match without RegWrite is not a hazard
    clear_inputs();
    ID_Branch = 1; ID_RegRs = 5'd9;
    EX_MemRead = 1; EX_RegWrAddr = 5'd9;
    cyc(54,  1,  1,  0, 0,  0, 8, 4, 0,  0);

    // reset in the middle of STALL1
    lw1_beq1();
    cyc(60,  0,  0,  0, 1,  0, 8, 4, 0,  0);
    reset = 1;
    cyc(61,  0,  0,  1, 1,  0, 0, 0, 1,  0);
    reset = 0;
    clear_inputs();
    ID_Branch = 1; ID_BranchTaken = 1; ID_RegRs = 5'd1; ID_RegRt = 5'd2;
    cyc(62,  1,  1,  1, 0,  0, 0, 0, 0,  0);
    clear_inputs();
    cyc(63,  1,  1,  0, 0,  0, 0, 1, 0,  0);

    waited = 0;
    while (sb.size() > 0 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    #1;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got=%0d pending want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
